// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, digest size, streamer FSM states,
// and the constant tables used by the compression core.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned DIGEST_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EMIT
  } state_e;

  localparam word_t H_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Word k of a 256-bit value, k=0 being the most significant (h0-aligned).
  function automatic word_t target_word(input logic [255:0] t, input int unsigned k);
    return t[255 - 32*k -: 32];
  endfunction

endpackage

// File: rtl/sha256_word_cmp.sv
// Incremental MSW-first magnitude comparator: fed one word pair per enabled
// cycle, it settles lt/eq on the first differing word and then holds.
module sha256_word_cmp
  import sha256_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  en_i,
  input  word_t word_i,
  input  word_t target_i,
  output logic  lt_o,
  output logic  eq_o
);

  logic lt_q, eq_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      lt_q <= 1'b0;
      eq_q <= 1'b1;
    end else if (en_i && eq_q) begin
      if (word_i < target_i) begin
        lt_q <= 1'b1;
        eq_q <= 1'b0;
      end else if (word_i > target_i) begin
        eq_q <= 1'b0;
      end
    end
  end

  assign lt_o = lt_q;
  assign eq_o = eq_q;

endmodule

// File: rtl/sha256_digest_streamer.sv
// Reads the digest words written by the SHA-256 core, streams them out h0
// first on valid/ready, and flags digest < target.
module sha256_digest_streamer #(
  parameter int unsigned DIGEST_WORDS = sha256_pkg::DIGEST_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  hash_addr,
  input  logic [255:0] target,
  output logic         memory_clk,
  output logic         memory_we,
  output logic [15:0]  memory_addr,
  input  logic [31:0]  memory_read_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         below_target,
  output logic         done
);

  import sha256_pkg::*;

  localparam int unsigned CW = $clog2(DIGEST_WORDS + 1);
  localparam int unsigned IW = $clog2(DIGEST_WORDS);

  state_e         state_q;
  logic [15:0]    addr_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  word_t          dbuf_q [DIGEST_WORDS];
  word_t          data_q;
  logic           valid_q, last_q, bvalid_q, done_q;

  logic [IW-1:0]  cap_idx, nidx;
  word_t          tgt_w;
  logic           cmp_clr, cmp_en, cmp_lt, cmp_eq;

  // cnt_q counts READ cycles; data returned in cycle c belongs to address c-1.
  always_comb begin
    cap_idx = IW'(cnt_q - CW'(1));
    nidx    = idx_q + IW'(1);
    tgt_w   = target_word(target, 32'(cap_idx));
    cmp_clr = (state_q == IDLE) && start;
    cmp_en  = (state_q == READ) && (cnt_q != '0) && cmp_eq;
  end

  sha256_word_cmp u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cmp_clr),
    .en_i     (cmp_en),
    .word_i   (memory_read_data),
    .target_i (tgt_w),
    .lt_o     (cmp_lt),
    .eq_o     (cmp_eq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      bvalid_q <= 1'b0;
      done_q   <= 1'b1;
      for (int unsigned i = 0; i < DIGEST_WORDS; i++) dbuf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= READ;
            addr_q   <= hash_addr;
            cnt_q    <= '0;
            bvalid_q <= 1'b0;
            done_q   <= 1'b0;
          end
        end
        READ: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q != '0) dbuf_q[cap_idx] <= memory_read_data;
          if (cnt_q < CW'(DIGEST_WORDS - 1)) addr_q <= addr_q + 16'd1;
          if (cnt_q == CW'(DIGEST_WORDS)) begin
            state_q  <= EMIT;
            idx_q    <= '0;
            valid_q  <= 1'b1;
            data_q   <= dbuf_q[0];
            last_q   <= (DIGEST_WORDS == 1);
            bvalid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (valid_q && out_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= nidx;
              data_q <= dbuf_q[nidx];
              last_q <= (nidx == IW'(DIGEST_WORDS - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The comparator holds its result after READ; bvalid_q gates it until the next start.
  assign below_target = bvalid_q & cmp_lt;
  assign memory_clk   = clk;
  assign memory_we    = 1'b0;
  assign memory_addr  = addr_q;
  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_last     = last_q;
  assign done         = done_q;

endmodule

// File: doc/sha256_digest_streamer.md
# sha256_digest_streamer

Downstream stage of the SHA-256 core. After the core reports `done`, this block reads the eight 32-bit digest words the core wrote at `hash_addr`. It streams them out, h0 first, on a valid/ready interface. It also flags whether the 256-bit digest is numerically below a supplied 256-bit target, for nonce/difficulty checking.

## Interface
- `DIGEST_WORDS`, default 8: number of 32-bit digest words read and streamed. Fixed at 8 for SHA-256.
- `clk`  in  1: single clock. Rising edge.
- `rst_n`  in  1: reset. Synchronous and active-low.
- `start`  in  1: begin a read/stream sequence. Sampled only in IDLE.
- `hash_addr`  in  16: word address of digest word h0.
- `target`  in  256: comparison threshold. `[255:224]` aligns with h0. Must be held stable from `start` until `done`.
- `memory_clk`  out  1: equal to `clk`.
- `memory_we`  out  1: always 0. This block only reads.
- `memory_addr`  out  16: registered read address.
- `memory_read_data`  in  32: data for the address presented on the previous cycle.
- `out_valid`  out  1: a stream word is available.
- `out_ready`  in  1: the consumer accepts the word.
- `out_data`  out  32: digest word.
- `out_last`  out  1: high with word `DIGEST_WORDS-1`.
- `below_target`  out  1: digest < `target`, unsigned 256-bit comparison. Valid from the first `out_valid` cycle until the next `start`.
- `done`  out  1: high whenever the FSM is in IDLE.

## Operation
- States:
  - IDLE, `done`=1.
  - READ: issue addresses and capture data.
  - EMIT: stream words.
- IDLE → READ on `start`:
  - `memory_addr` ← `hash_addr`.
  - Read index ← 0.
  - Comparator flags reset: `eq`=1, `lt`=0.
- READ, each cycle:
  - Advance `memory_addr` by 1 until `hash_addr+DIGEST_WORDS-1` has been presented.
  - Capture `memory_read_data` into `buf[k]`.
  - Update the comparator MSW-first:
    - If `eq` and `word < target_word[k]`: `lt`←1, `eq`←0.
    - If `eq` and `word > target_word[k]`: `eq`←0.
    - Otherwise the flags hold.
- After `buf[DIGEST_WORDS-1]` is captured:
  - `below_target` ← `lt`.
  - State → EMIT with index 0.
- EMIT:
  - `out_valid`=1 and `out_data`=`buf[idx]`.
  - `out_last` = (`idx`==`DIGEST_WORDS-1`).
  - On a handshake (`out_valid && out_ready`), idx increments.
  - A handshake with `out_last` → IDLE, and `out_valid` drops the next cycle.
- Address arithmetic is modulo 2^16. `hash_addr`=16'hFFFE reads FFFE, FFFF, 0000 … 0005.
- `start` is ignored outside IDLE.
- `out_data`/`out_last` must not change while `out_valid && !out_ready`.
- Equal digest and target gives `below_target`=0.

## Timing
- `start` sampled high at edge T, IDLE:
  - `memory_addr`=`hash_addr`+k during cycle T+1+k, for k=0..7.
  - Word k is captured at the end of cycle T+2+k.
- First `out_valid` in cycle T+10. `below_target` is valid in the same cycle.
- With `out_ready` held 1: words stream in cycles T+10..T+17, `out_last` in T+17, and `done` rises in T+18.
- Each stalled cycle (`out_ready`=0) extends the sequence by 1 cycle. There is no limit.
- Back-to-back: `start` high in the cycle `done` rises begins a new sequence with the same T-relative timing.
- `rst_n` low at any edge, including mid-READ or mid-EMIT, forces on the next cycle:
  - State IDLE.
  - `memory_addr`=0, `memory_we`=0.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `below_target`=0, `done`=1.
  - Buffered words discarded.

## Structure
- Shared package `sha256_pkg`:
  - Typedef `word_t` (32-bit).
  - Constant `DIGEST_WORDS`=8.
  - State enum `{IDLE, READ, EMIT}`.
  - Constants shared with the core (hash IVs, K table).
- One natural sub-module, `sha256_word_cmp`: the incremental MSW-first magnitude comparator. Inputs are a word, the target word, a clear and an enable. Outputs are `lt` and `eq`.
- The 8×32 digest buffer and the FSM live in the top module.

## Test plan
- Memory at 0x0100 holds `ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad` ("abc" digest); `out_ready`=1; `start` at T → the eight words appear in order in T+10..T+17, `out_last` only at T+17, `done` rises at T+18.
- Same memory, `target`={`ba7816c0`, 224'h0} → `below_target`=1. With `target`=the digest itself → 0. With `target`={`ba7816bf`, `8f01cfe9`, 192'hF…F} → 0.
- `out_ready` toggling 1,0,0,1,… → no word dropped or duplicated; `out_data` stable during stalls; total handshakes = 8.
- `hash_addr`=16'hFFFD → `memory_addr` sequence FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003, 0004.
- `rst_n` low for one edge during EMIT after 3 words → next cycle `out_valid`=0, `done`=1, `below_target`=0; a following `start` streams all 8 words from word 0.
- `start` pulsed during READ and during EMIT → ignored; exactly one 8-word stream.
